// File: rtl/dff_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arb
// Description : Shared WIDTH-bit register written by four requesters through
//               a round-robin arbiter. Each write takes a GRANT cycle followed
//               by a RECOVER cycle, so sustained throughput is one write per
//               two clocks. Tracks the last writer and a wrapping write count.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     d,
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          q,
    output logic [$clog2(NREQ)-1:0]   last_id,
    output logic [7:0]                wr_cnt,
    output logic                      busy
);

    // Requester index width; the pointer arithmetic relies on NREQ being a
    // power of two so that index overflow is the modulo-NREQ wrap.
    localparam int                c_ID_W   = $clog2(NREQ);
    localparam logic [c_ID_W-1:0] c_ID_ONE = c_ID_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t              state_q;
    logic [c_ID_W-1:0]   ptr_q;      // highest-priority requester for next arbitration
    logic [c_ID_W-1:0]   gidx_q;     // index of the requester currently granted
    logic [NREQ-1:0]     gnt_q;
    logic [WIDTH-1:0]    q_q;
    logic [c_ID_W-1:0]   last_id_q;
    logic [7:0]          wr_cnt_q;

    logic [WIDTH-1:0]    w_d_arr [NREQ];
    logic [c_ID_W-1:0]   w_cand;
    logic [c_ID_W-1:0]   w_win_idx;
    logic                w_win_vld;
    logic [NREQ-1:0]     w_win_oh;
    logic [WIDTH-1:0]    w_d_sel;

    // Split the packed data bus into one slice per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_d_arr[gi] = d[gi*WIDTH +: WIDTH];
    end

    // Round-robin pick: first set request bit scanning upward from ptr_q,
    // wrapping past the top index back to 0.
    always_comb begin
        w_cand    = '0;
        w_win_idx = '0;
        w_win_vld = 1'b0;
        w_win_oh  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = ptr_q + k[c_ID_W-1:0];
            if (!w_win_vld && req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
        if (w_win_vld) begin
            w_win_oh[w_win_idx] = 1'b1;
        end
    end

    // Data of the granted requester, captured on the GRANT exit edge.
    assign w_d_sel = w_d_arr[gidx_q];

    // Arbitration FSM with all outputs registered; reset cancels any write
    // in flight because it overrides the GRANT branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            gnt_q     <= '0;
            q_q       <= '0;
            last_id_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE, RECOVER: begin
                    if (w_win_vld) begin
                        state_q <= GRANT;
                        gnt_q   <= w_win_oh;
                        gidx_q  <= w_win_idx;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                    end
                end
                GRANT: begin
                    // Commit the write; requests are ignored in this cycle.
                    q_q       <= w_d_sel;
                    last_id_q <= gidx_q;
                    wr_cnt_q  <= wr_cnt_q + 8'd1;
                    ptr_q     <= gidx_q + c_ID_ONE;
                    gnt_q     <= '0;
                    state_q   <= RECOVER;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign last_id = last_id_q;
    assign wr_cnt  = wr_cnt_q;
    assign busy    = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_bank_arb
// Description : Directed self-checking bench for dff_bank_arb. Expected writes
//               are queued when requests are driven; a monitor pops them as
//               grants appear and tracks the register contents expected.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arb;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = '0;
    logic [4*W-1:0] d   = '0;
    logic [3:0]     gnt;
    logic [W-1:0]   q;
    logic [1:0]     last_id;
    logic [7:0]     wr_cnt;
    logic           busy;

    dff_bank_arb #(.WIDTH(W), .NREQ(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .q       (q),
        .last_id (last_id),
        .wr_cnt  (wr_cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [3:0] g;
        logic [7:0] data;
        logic [1:0] id;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur;
    bit         pending = 1'b0;
    logic [7:0] m_q     = '0;
    logic [7:0] m_cnt   = '0;
    logic [1:0] m_id    = '0;
    logic       rst_prev = 1'b1;

    always @(posedge clk) rst_prev <= rst;

    always @(negedge clk) begin
        if (rst_prev) begin
            pending = 1'b0;
            m_q     = '0;
            m_cnt   = '0;
            m_id    = '0;
            check("rst_gnt",     32'(gnt),     32'd0);
            check("rst_q",       32'(q),       32'd0);
            check("rst_wr_cnt",  32'(wr_cnt),  32'd0);
            check("rst_last_id", 32'(last_id), 32'd0);
            check("rst_busy",    32'(busy),    32'd0);
        end else begin
            if (pending) begin
                m_q     = cur.data;
                m_id    = cur.id;
                m_cnt   = m_cnt + 8'd1;
                pending = 1'b0;
            end
            check("sb_q",       32'(q),       32'(m_q));
            check("sb_last_id", 32'(last_id), 32'(m_id));
            check("sb_wr_cnt",  32'(wr_cnt),  32'(m_cnt));
            if (gnt != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("sb_gnt", 32'(gnt), 32'(cur.g));
                    pending = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic push_exp(input int id, input logic [7:0] data);
        exp_t e;
        e.g    = 4'b0001 << id;
        e.data = data;
        e.id   = id[1:0];
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for a grant; lat = edges taken, 8 on timeout.
    task automatic wait_gnt(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (gnt == 4'd0 && lat < 8);
    endtask

    // One isolated write by requester id; returns just after the commit edge.
    task automatic single_write(input int id, input logic [7:0] data);
        int lat;
        push_exp(id, data);
        d[id*W +: W] = data;
        req = 4'b0001 << id;
        wait_gnt(lat);
        check("wr_gnt_latency", 32'(lat),  32'd1);
        check("wr_busy_grant",  32'(busy), 32'd1);
        req = '0;
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int         lat;
        logic [3:0] expv;
        logic [7:0] last_data;

        // Reset state
        do_reset();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_gnt",  32'(gnt),  32'd0);

        // Single requester 2 writes A5; first arbitration right after reset
        single_write(2, 8'hA5);
        check("single_q",       32'(q),       32'hA5);
        check("single_last_id", 32'(last_id), 32'd2);
        check("single_wr_cnt",  32'(wr_cnt),  32'd1);
        check("single_gnt_off", 32'(gnt),     32'd0);
        tick();

        // Fairness: all four requesting continuously
        do_reset();
        d = {8'h44, 8'h33, 8'h22, 8'h11};
        push_exp(0, 8'h11);
        push_exp(1, 8'h22);
        push_exp(2, 8'h33);
        push_exp(3, 8'h44);
        push_exp(0, 8'h11);
        req = 4'hF;
        wait_gnt(lat);
        check("fair_lat",  32'(lat), 32'd1);
        check("fair_gnt0", 32'(gnt), 32'h1);
        for (int i = 1; i < 10; i++) begin
            tick();
            expv = (i % 2 == 1) ? 4'd0 : (4'b0001 << ((i / 2) % 4));
            check("fair_gnt_seq", 32'(gnt), 32'(expv));
            if (i == 8) req = '0;
        end
        check("fair_wr_cnt",  32'(wr_cnt),  32'd5);
        check("fair_last_id", 32'(last_id), 32'd0);
        check("fair_q",       32'(q),       32'h11);
        tick();

        // Pointer rotation: grant 1, then {1,0} request -> 0 wins, then 1
        single_write(1, 8'h5A);
        d[7:0]  = 8'hC3;
        d[15:8] = 8'h96;
        push_exp(0, 8'hC3);
        push_exp(1, 8'h96);
        req = 4'b0011;
        wait_gnt(lat);
        check("rot_lat",  32'(lat), 32'd1);
        check("rot_gnt",  32'(gnt), 32'b0001);
        req = 4'b0010;
        tick();
        check("rot_q", 32'(q), 32'hC3);
        wait_gnt(lat);
        check("rot_lat2", 32'(lat), 32'd1);
        check("rot_gnt2", 32'(gnt), 32'b0010);
        req = '0;
        tick();
        check("rot_q2", 32'(q), 32'h96);
        tick();

        // Reset during GRANT cancels the write
        do_reset();
        d[7:0] = 8'hFF;
        push_exp(0, 8'hFF);
        req = 4'b0001;
        wait_gnt(lat);
        check("midrst_lat", 32'(lat), 32'd1);
        rst = 1'b1;
        req = '0;
        tick();
        check("midrst_q",      32'(q),      32'd0);
        check("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
        check("midrst_gnt",    32'(gnt),    32'd0);
        check("midrst_busy",   32'(busy),   32'd0);
        rst = 1'b0;

        // Counter wrap over 256 writes
        do_reset();
        last_data = '0;
        for (int i = 0; i < 256; i++) begin
            last_data = 8'(i * 7 + 3);
            single_write(i % 4, last_data);
            if (i == 254) check("wrap_cnt_255", 32'(wr_cnt), 32'd255);
        end
        check("wrap_cnt_0", 32'(wr_cnt), 32'd0);
        check("wrap_q",     32'(q),      32'(last_data));

        // Idle after a write of 3C
        single_write(3, 8'h3C);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("idle_gnt",  32'(gnt),  32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_q",    32'(q),    32'h3C);
            tick();
        end

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        check("sb_no_pending",  32'(pending),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire

// File: doc/dff_bank_arb.md
DFF_BANK_ARB -- requirements
Module: dff_bank_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, which is the bit width of the shared register and of each requester data slice.
REQ-002 SHALL have parameter NREQ, fixed at 4, which is the number of requesters; other values are not supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 4 bits: write request, one bit per requester; bit i belongs to requester i.
REQ-006 SHALL have port d, input, 4*WIDTH bits: packed write data; requester i uses d[i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt, output, 4 bits: one-hot write grant, registered.
REQ-008 SHALL have port q, output, WIDTH bits: shared register contents, registered.
REQ-009 SHALL have port last_id, output, 2 bits: index of the requester that performed the most recent write.
REQ-010 SHALL have port wr_cnt, output, 8 bits: count of completed writes.
REQ-011 SHALL have port busy, output, 1 bit: high while the FSM is in GRANT or RECOVER.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, GRANT and RECOVER.
REQ-013 In IDLE or RECOVER at a rising edge: if req != 0, the FSM SHALL go to GRANT and load gnt with the one-hot winner; otherwise it SHALL go to IDLE with gnt = 0.
REQ-014 The winner SHALL be chosen round-robin: scan from index ptr upward, modulo 4; the first set req bit wins.
REQ-015 In GRANT at the next rising edge, all of the following SHALL happen together:
- q <= d slice of the granted requester;
- last_id <= granted index;
- wr_cnt <= wr_cnt + 1;
- ptr <= granted index + 1 (mod 4);
- gnt <= 0;
- state <= RECOVER.
REQ-016 gnt SHALL be high for exactly one cycle per grant and SHALL never have more than one bit set.
REQ-017 Write latency SHALL be as follows: req sampled at edge k -> gnt visible after edge k -> new q visible after edge k+1.
REQ-018 In GRANT, req is not sampled; a requester SHALL hold req and its d slice stable until it observes gnt, and deassert req before edge k+2.
REQ-019 Sustained throughput SHALL be one write per two cycles (GRANT, RECOVER, GRANT, ...).
REQ-020 A requester whose req is still high in RECOVER SHALL receive a grant only when no higher round-robin-priority req bit is set.
REQ-021 wr_cnt SHALL wrap from 255 to 0 without saturation or flag.
REQ-022 q, last_id and wr_cnt SHALL hold their value in every cycle that is not a GRANT-exit edge.
REQ-023 busy SHALL be 1 in GRANT and RECOVER and 0 in IDLE.

Reset
REQ-024 On a rising edge with rst = 1, the block SHALL set state = IDLE, gnt = 0, q = 0, last_id = 0, wr_cnt = 0 and ptr = 0; requester 0 has highest priority after reset.
REQ-025 rst SHALL take precedence over all other activity; rst asserted during GRANT SHALL cancel that write (q and wr_cnt are not updated).
REQ-026 The first arbitration after reset SHALL occur at the first edge with rst = 0.

Verification
REQ-027 Bench SHALL cover single requester:
- stimulus: after reset, req = 4'b0100, d slice 2 = 8'hA5;
- response: gnt = 4'b0100 for one cycle; q = 8'hA5, last_id = 2, wr_cnt = 1 one cycle later.
REQ-028 Bench SHALL cover fairness:
- stimulus: after reset, all req = 4'b1111 held continuously;
- response: grants in order 0,1,2,3,0 on alternating cycles; wr_cnt = 5 after the fifth write.
REQ-029 Bench SHALL cover pointer rotation:
- stimulus: grant requester 1; then req = 4'b0011;
- response: next grant goes to requester 0, because ptr = 2 wraps to 0 before reaching 1.
REQ-030 Bench SHALL cover reset mid-operation:
- stimulus: rst = 1 during the GRANT cycle, with d slice = 8'hFF;
- response: q remains 0, wr_cnt remains 0, gnt = 0 and busy = 0 after the edge.
REQ-031 Bench SHALL cover wrap-around:
- stimulus: 256 consecutive writes;
- response: wr_cnt returns to 0 and q equals the last written data.
REQ-032 Bench SHALL cover idle:
- stimulus: req = 0 for 10 cycles after a write of 8'h3C;
- response: gnt = 0 and busy = 0 throughout; q holds 8'h3C.
